// File: rtl/ahb_pkg.sv
// AHB-Lite definitions shared by the SoC RAM port and the scrubber.
// scrub_pattern() is the address-derived word written and later verified.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HBURST_SINGLE   = 3'b000;
  localparam logic [2:0] HSIZE_64        = 3'b011;
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

  function automatic logic [63:0] scrub_pattern(input logic [31:0] addr);
    return {~addr, addr};
  endfunction

endpackage

// File: rtl/ahb_sram_scrubber.sv
// AHB-Lite initiator: writes scrub_pattern() over a 64-bit SRAM window, reads it
// back and reports mismatches / bus errors. Single pipelined transfer at a time.
module ahb_sram_scrubber
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned WORDS     = 4096
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [31:0] o_err_addr,
  output logic [15:0] o_mismatch_cnt,
  output logic [31:0] o_haddr,
  output logic [2:0]  o_hburst,
  output logic [2:0]  o_hsize,
  output logic [3:0]  o_hprot,
  output logic [1:0]  o_htrans,
  output logic [63:0] o_hwdata,
  output logic        o_hwrite,
  input  logic [63:0] i_hrdata,
  input  logic        i_hresp,
  input  logic        i_hready
);

  localparam int unsigned CNT_W = $clog2(WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WDRAIN,
    ST_READ,
    ST_RDRAIN,
    ST_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  htrans_t           htrans_reg, htrans_next;
  logic [31:0]       haddr_reg, haddr_next;
  logic              hwrite_reg, hwrite_next;
  logic [63:0]       hwdata_reg, hwdata_next;
  logic [2:0]        hburst_reg, hsize_reg;
  logic [3:0]        hprot_reg;

  // Bookkeeping for the transfer currently in its data phase.
  logic              dp_valid_reg, dp_valid_next;
  logic              dp_write_reg, dp_write_next;
  logic [31:0]       dp_addr_reg, dp_addr_next;

  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              error_reg, error_next;
  logic [31:0]       err_addr_reg, err_addr_next;
  logic [15:0]       mismatch_reg, mismatch_next;

  logic              active;
  logic              last_addr;
  logic              bus_err_first;
  logic              bus_err_second;
  logic              rd_mismatch;

  always_comb begin
    active = (state_reg == ST_WRITE) || (state_reg == ST_WDRAIN) ||
             (state_reg == ST_READ)  || (state_reg == ST_RDRAIN);
    last_addr      = (cnt_reg == LAST_IDX);
    bus_err_first  = active && dp_valid_reg && i_hresp && !i_hready;
    bus_err_second = active && dp_valid_reg && i_hresp && i_hready;
    rd_mismatch    = active && dp_valid_reg && !dp_write_reg && i_hready && !i_hresp &&
                     (i_hrdata != scrub_pattern(dp_addr_reg));
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    htrans_next   = htrans_reg;
    haddr_next    = haddr_reg;
    hwrite_next   = hwrite_reg;
    hwdata_next   = hwdata_reg;
    dp_valid_next = dp_valid_reg;
    dp_write_next = dp_write_reg;
    dp_addr_next  = dp_addr_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    error_next    = error_reg;
    err_addr_next = err_addr_reg;
    mismatch_next = mismatch_reg;

    // An accepted address phase becomes the next data phase.
    if (active && i_hready) begin
      dp_valid_next = (htrans_reg == NONSEQ);
      dp_write_next = hwrite_reg;
      dp_addr_next  = haddr_reg;
    end

    case (state_reg)
      ST_IDLE: begin
        if (i_start) begin
          state_next    = ST_WRITE;
          htrans_next   = NONSEQ;
          haddr_next    = BASE_ADDR;
          hwrite_next   = 1'b1;
          cnt_next      = '0;
          busy_next     = 1'b1;
          error_next    = 1'b0;
          err_addr_next = '0;
          mismatch_next = '0;
          dp_valid_next = 1'b0;
        end
      end
      ST_WRITE: begin
        if (i_hready) begin
          hwdata_next = scrub_pattern(haddr_reg);
          if (last_addr) begin
            state_next  = ST_WDRAIN;
            htrans_next = IDLE;
          end else begin
            cnt_next   = cnt_reg + CNT_ONE;
            haddr_next = haddr_reg + 32'd8;
          end
        end
      end
      ST_WDRAIN: begin
        if (i_hready) begin
          state_next  = ST_READ;
          htrans_next = NONSEQ;
          haddr_next  = BASE_ADDR;
          hwrite_next = 1'b0;
          cnt_next    = '0;
        end
      end
      ST_READ: begin
        if (i_hready) begin
          if (last_addr) begin
            state_next  = ST_RDRAIN;
            htrans_next = IDLE;
          end else begin
            cnt_next   = cnt_reg + CNT_ONE;
            haddr_next = haddr_reg + 32'd8;
          end
        end
      end
      ST_RDRAIN: begin
        if (i_hready) begin
          state_next = ST_DONE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase

    if (rd_mismatch) begin
      error_next = 1'b1;
      if (!error_reg) err_addr_next = dp_addr_reg;
      if (mismatch_reg != 16'hFFFF) mismatch_next = mismatch_reg + 16'd1;
    end

    // Two-cycle ERROR: cancel the pending address phase, then abandon the scan.
    if (bus_err_first) begin
      htrans_next = IDLE;
      error_next  = 1'b1;
      if (!error_reg) err_addr_next = dp_addr_reg;
    end

    if (bus_err_second) begin
      state_next    = ST_DONE;
      htrans_next   = IDLE;
      busy_next     = 1'b0;
      done_next     = 1'b1;
      dp_valid_next = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      htrans_reg   <= IDLE;
      haddr_reg    <= '0;
      hwrite_reg   <= 1'b0;
      hwdata_reg   <= '0;
      hburst_reg   <= '0;
      hsize_reg    <= '0;
      hprot_reg    <= '0;
      dp_valid_reg <= 1'b0;
      dp_write_reg <= 1'b0;
      dp_addr_reg  <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
      err_addr_reg <= '0;
      mismatch_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      htrans_reg   <= htrans_next;
      haddr_reg    <= haddr_next;
      hwrite_reg   <= hwrite_next;
      hwdata_reg   <= hwdata_next;
      hburst_reg   <= HBURST_SINGLE;
      hsize_reg    <= HSIZE_64;
      hprot_reg    <= HPROT_DATA_PRIV;
      dp_valid_reg <= dp_valid_next;
      dp_write_reg <= dp_write_next;
      dp_addr_reg  <= dp_addr_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      error_reg    <= error_next;
      err_addr_reg <= err_addr_next;
      mismatch_reg <= mismatch_next;
    end
  end

  assign o_busy         = busy_reg;
  assign o_done         = done_reg;
  assign o_error        = error_reg;
  assign o_err_addr     = err_addr_reg;
  assign o_mismatch_cnt = mismatch_reg;
  assign o_haddr        = haddr_reg;
  assign o_hburst       = hburst_reg;
  assign o_hsize        = hsize_reg;
  assign o_hprot        = hprot_reg;
  assign o_htrans       = htrans_reg;
  assign o_hwdata       = hwdata_reg;
  assign o_hwrite       = hwrite_reg;

endmodule

// File: tb/tb_ahb_sram_scrubber.sv
// Bench: two scrubbers (16 and 64 words) on a modelled AHB SRAM responder with
// stalls, read corruption and ERROR injection; scoreboard of addresses and results.
`timescale 1ns/1ps
module tb_ahb_sram_scrubber;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start    [2];
  logic        busy     [2];
  logic        done     [2];
  logic        error    [2];
  logic [31:0] err_addr [2];
  logic [15:0] mm       [2];
  logic [31:0] haddr    [2];
  logic [2:0]  hburst   [2];
  logic [2:0]  hsize    [2];
  logic [3:0]  hprot    [2];
  logic [1:0]  htrans   [2];
  logic [63:0] hwdata   [2];
  logic        hwrite   [2];
  logic [63:0] hrdata   [2];
  logic        hresp    [2];
  logic        hready   [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    ahb_sram_scrubber #(
      .BASE_ADDR(32'h0000_0000),
      .WORDS    (gi == 0 ? 16 : 64)
    ) u_dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_start       (start[gi]),
      .o_busy        (busy[gi]),
      .o_done        (done[gi]),
      .o_error       (error[gi]),
      .o_err_addr    (err_addr[gi]),
      .o_mismatch_cnt(mm[gi]),
      .o_haddr       (haddr[gi]),
      .o_hburst      (hburst[gi]),
      .o_hsize       (hsize[gi]),
      .o_hprot       (hprot[gi]),
      .o_htrans      (htrans[gi]),
      .o_hwdata      (hwdata[gi]),
      .o_hwrite      (hwrite[gi]),
      .i_hrdata      (hrdata[gi]),
      .i_hresp       (hresp[gi]),
      .i_hready      (hready[gi])
    );
  end

  typedef struct {
    logic [31:0] addr;
    logic        w;
  } exp_addr_t;

  typedef struct {
    logic [15:0] mm;
    logic [31:0] ea;
    logic        er;
    int          cycles;
  } exp_res_t;

  exp_addr_t   exp_addr_q[$];
  exp_res_t    exp_res_q[$];
  logic [63:0] mem [logic [31:0]];

  int n_checks = 0;
  int n_errors = 0;

  int stall_pct  = 0;
  bit corrupt_en = 0;
  bit err_en     = 0;
  int err_phase  = 0;
  int stall_cnt  = 0;
  localparam logic [31:0] ERR_ADDR = 32'h28;

  // Responder state per DUT
  logic        dp_v       [2];
  logic        dp_w       [2];
  logic [31:0] dp_a       [2];
  logic        prev_stall [2];
  logic        prev_ctl_v [2];
  logic [34:0] prev_ctl   [2];
  logic        prev_wd_v  [2];
  logic [63:0] prev_wd    [2];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pat(input logic [31:0] a);
    return {~a, a};
  endfunction

  task automatic respond_step(input int id);
    exp_addr_t   e;
    logic [63:0] rd;
    if (!rst_n) begin
      dp_v[id] = 1'b0; prev_stall[id] = 1'b0;
      hready[id] = 1'b1; hresp[id] = 1'b0; hrdata[id] = '0;
      return;
    end
    if (prev_stall[id] && prev_ctl_v[id])
      check("ctl_hold", 64'({htrans[id], haddr[id], hwrite[id]}), 64'(prev_ctl[id]));
    if (prev_stall[id] && prev_wd_v[id])
      check("hwdata_hold", hwdata[id], prev_wd[id]);

    hready[id] = 1'b1;
    hresp[id]  = 1'b0;
    if (dp_v[id] && !dp_w[id]) begin
      rd = mem.exists(dp_a[id]) ? mem[dp_a[id]] : 64'h0;
      if (corrupt_en && (dp_a[id] == 32'h40 || dp_a[id] == 32'h80)) rd = rd ^ 64'h1;
      hrdata[id] = rd;
    end
    if (err_en && id == 1 && dp_v[id] && dp_w[id] && dp_a[id] == ERR_ADDR) begin
      if (err_phase == 0) begin
        hresp[id] = 1'b1; hready[id] = 1'b0; err_phase = 1;
      end else if (err_phase == 1) begin
        check("htrans_after_err", 64'(htrans[id]), 64'(2'b00));
        hresp[id] = 1'b1; hready[id] = 1'b1; err_phase = 2;
      end
    end else if (dp_v[id] && stall_pct > 0 && $urandom_range(99) < stall_pct) begin
      hready[id] = 1'b0;
    end

    if (!hready[id] && !hresp[id] && busy[id]) stall_cnt++;
    prev_stall[id] = !hready[id] && !hresp[id];
    prev_ctl_v[id] = (htrans[id] == 2'b10);
    prev_ctl[id]   = {htrans[id], haddr[id], hwrite[id]};
    prev_wd_v[id]  = dp_v[id] && dp_w[id];
    prev_wd[id]    = hwdata[id];

    if (hready[id]) begin
      if (dp_v[id] && dp_w[id] && !hresp[id]) begin
        check("hwdata", hwdata[id], pat(dp_a[id]));
        mem[dp_a[id]] = hwdata[id];
      end
      if (htrans[id] == 2'b10) begin
        check("addr_expected", 64'(exp_addr_q.size() != 0), 64'(1));
        if (exp_addr_q.size() != 0) begin
          e = exp_addr_q.pop_front();
          check("haddr", 64'(haddr[id]), 64'(e.addr));
          check("hwrite", 64'(hwrite[id]), 64'(e.w));
        end
        check("hctl", 64'({hburst[id], hsize[id], hprot[id]}), 64'(10'b000_011_0011));
        dp_v[id] = 1'b1; dp_w[id] = hwrite[id]; dp_a[id] = haddr[id];
      end else begin
        dp_v[id] = 1'b0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      hready[i] = 1'b1; hresp[i] = 1'b0; hrdata[i] = '0;
      dp_v[i] = 1'b0; prev_stall[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      respond_step(0);
      respond_step(1);
    end
  end

  task automatic check_reset_outputs(input int id);
    check("rst_ctl", {haddr[id], htrans[id], hwrite[id], hburst[id], hsize[id], hprot[id],
                      busy[id], done[id], error[id], mm[id]}, 64'h0);
    check("rst_hwdata", hwdata[id], 64'h0);
    check("rst_err_addr", 64'(err_addr[id]), 64'h0);
  endtask

  task automatic push_seq(input int n_wr, input int n_rd);
    exp_addr_t e;
    for (int k = 0; k < n_wr; k++) begin e.addr = 32'(8 * k); e.w = 1'b1; exp_addr_q.push_back(e); end
    for (int k = 0; k < n_rd; k++) begin e.addr = 32'(8 * k); e.w = 1'b0; exp_addr_q.push_back(e); end
  endtask

  task automatic push_res(input logic [15:0] m, input logic [31:0] ea, input logic er, input int c);
    exp_res_t r;
    r.mm = m; r.ea = ea; r.er = er; r.cycles = c;
    exp_res_q.push_back(r);
  endtask

  task automatic launch(input int id, output int s);
    @(negedge clk);
    s = cyc;
    start[id] = 1'b1;
    stall_cnt = 0;
    @(negedge clk);
    start[id] = 1'b0;
    check("busy_after_start", 64'(busy[id]), 64'(1));
  endtask

  task automatic wait_done(input int id, input int s, output int d);
    exp_res_t r;
    int n = 0;
    while (!done[id] && n < 20000) begin
      @(negedge clk);
      n++;
    end
    d = cyc;
    check("done_seen", 64'(done[id]), 64'(1));
    if (done[id] && exp_res_q.size() != 0) begin
      r = exp_res_q.pop_front();
      check("mismatch_cnt", 64'(mm[id]), 64'(r.mm));
      check("err_addr", 64'(err_addr[id]), 64'(r.ea));
      check("error", 64'(error[id]), 64'(r.er));
      check("cycles", 64'(d - s + 1), 64'(r.cycles + stall_cnt));
      check("busy_in_done", 64'(busy[id]), 64'(0));
      $display("run dut%0d: cycles=%0d stalls=%0d mismatches=%0d error=%0b err_addr=%h",
               id, d - s + 1, stall_cnt, mm[id], error[id], err_addr[id]);
    end
  endtask

  initial begin
    int s, d, s2;
    start[0] = 1'b0;
    start[1] = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs(0);
    check_reset_outputs(1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Zero-wait, 16 words
    push_seq(16, 16);
    push_res(16'd0, 32'h0, 1'b0, 36);
    launch(0, s);
    wait_done(0, s, d);
    check("word3_data", mem[32'h18], 64'hFFFFFFE7_00000018);

    // Random stalls, 64 words
    stall_pct = 30;
    push_seq(64, 64);
    push_res(16'd0, 32'h0, 1'b0, 132);
    launch(1, s);
    wait_done(1, s, d);
    stall_pct = 0;

    // Corrupted read data at 0x40 and 0x80
    corrupt_en = 1'b1;
    push_seq(64, 64);
    push_res(16'd2, 32'h40, 1'b1, 132);
    launch(1, s);
    wait_done(1, s, d);
    corrupt_en = 1'b0;

    // ERROR response on write to 0x28
    err_en = 1'b1;
    err_phase = 0;
    push_seq(6, 0);
    push_res(16'd0, 32'h28, 1'b1, 10);
    launch(1, s);
    wait_done(1, s, d);
    repeat (5) @(negedge clk);
    check("queue_after_err", 64'(exp_addr_q.size()), 64'(0));
    check("err_phase_used", 64'(err_phase), 64'(2));
    err_en = 1'b0;

    // Reset in the middle of the write pass
    push_seq(64, 64);
    launch(1, s);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs(1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_addr_q.delete();
    @(negedge clk);
    push_seq(64, 64);
    push_res(16'd0, 32'h0, 1'b0, 132);
    launch(1, s);
    wait_done(1, s, d);

    // start held high across two back-to-back runs
    push_seq(16, 16);
    push_seq(16, 16);
    push_res(16'd0, 32'h0, 1'b0, 36);
    push_res(16'd0, 32'h0, 1'b0, 36);
    @(negedge clk);
    s = cyc;
    start[0] = 1'b1;
    stall_cnt = 0;
    wait_done(0, s, d);
    @(negedge clk);
    check("idle_after_done", 64'({busy[0], htrans[0]}), 64'(0));
    s2 = cyc;
    @(negedge clk);
    check("rerun_started", 64'({busy[0], htrans[0], haddr[0]}), 64'({1'b1, 2'b10, 32'h0}));
    start[0] = 1'b0;
    stall_cnt = 0;
    wait_done(0, s2, d);
    repeat (40) @(negedge clk);
    check("no_third_run", 64'(busy[0]), 64'(0));
    check("queue_drained", 64'(exp_addr_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
